stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Six-digit BCD stopwatch (MM:SS.cc) counting hundredths of a second. It sits directly downstream of the 100 Hz clock divider. The divider's 100 Hz square wave is sampled as a data input in the system clock domain, never used as a clock. Start/stop, clear and lap pushbuttons (already debounced) control a small state machine. BCD digit outputs feed the seven-segment display stage.

## Interface
- `MIN_LIMIT`, default 60: minute count wraps to 00 on reaching this value. Legal range 1–99.
- `clk` in 1: system clock, 50 MHz. The only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `tick100` in 1: 100 Hz square wave from the clock divider. Synchronous to `clk`.
- `btn_start` in 1: start/stop request, level. Its rising edge is the event.
- `btn_clear` in 1: clear request, level. Its rising edge is the event.
- `btn_lap` in 1: lap freeze request, level. Its rising edge is the event.
- `cs_ones`, `cs_tens` out 4 each: hundredths digits, BCD.
- `s_ones`, `s_tens` out 4 each: seconds digits, BCD.
- `m_ones`, `m_tens` out 4 each: minutes digits, BCD.
- `running` out 1: high while in state RUN.
- `lap_active` out 1: high while the display is frozen.
- `rollover` out 1: one-`clk` pulse when the count wraps past the maximum value to 00:00.00.

## Operation
- Edge detection:
  - One register per input: `tick_q`, `start_q`, `clear_q`, `lap_q`.
  - An event is `x & ~x_q`.
  - `tick_q` resets to 1. This ensures a high `tick100` at reset release is not counted. The other edge registers reset to 0.
- States:
  - IDLE (count zero, stopped), RUN, PAUSED.
  - IDLE, start event → RUN.
  - RUN, start event → PAUSED.
  - PAUSED, start event → RUN.
  - Any state, clear event → IDLE. All count digits zeroed and the lap freeze released.
- Priority when events coincide in the same cycle: clear > start > tick.
  - A tick event is counted only if the state register is RUN at that edge.
  - RUN with start event and tick event in the same cycle: the increment happens, and the state becomes PAUSED.
  - IDLE with start event and tick event in the same cycle: no increment, and the state becomes RUN.
- Counting: one increment per tick event, as a BCD ripple:
  - `cs_ones` 9→0 carries into `cs_tens`.
  - `cs_tens` 9→0 carries into `s_ones`.
  - `s_ones` 9→0 carries into `s_tens`.
  - `s_tens` 5→0 carries into the minutes.
  - Minutes increment in BCD. When the value would equal `MIN_LIMIT`, the minutes go to 00.
  - The full wrap (e.g. 59:59.99 → 00:00.00 with the default) asserts `rollover` for that single cycle. The state stays RUN.
- Every digit always stays a legal BCD value (0–9, tens-of-seconds 0–5). No intermediate invalid value is ever visible.
- Lap (only with `STOPWATCH_LAP_EN`):
  - A lap event in RUN with `lap_active`=0 copies the live count into display hold registers and sets `lap_active`.
  - The outputs then show the held value while the internal count keeps running.
  - A second lap event, in any state, clears `lap_active`. The outputs return to the live count.
  - A lap event in IDLE or PAUSED while not frozen is ignored.
  - A clear event releases the freeze.

## Timing
- Reset (`reset_n`=0 at a `clk` edge):
  - All digits 0, state IDLE.
  - `running`=0, `lap_active`=0, `rollover`=0.
  - Hold registers 0, `tick_q`=1.
- Latency:
  - Digit outputs and `running` are registered. They change at the same `clk` edge that samples the qualifying event, i.e. one cycle after the input rises.
  - `rollover` is high for exactly the cycle following that edge.
- Reset asserted mid-count: digits are zero at the next edge. There is no partial carry.
- Button held high: it produces only one event. A new event needs a low sample first.
- `tick100` high for many cycles: exactly one increment per rising edge, giving 100 increments per second at 50 MHz.

## Configuration
- `STOPWATCH_LAP_EN` defined: lap freeze logic and hold registers are compiled in, as described above.
- `STOPWATCH_LAP_EN` undefined:
  - `btn_lap` is ignored (port kept) and `lap_active` is tied to 0.
  - Outputs always show the live count, and no hold registers are synthesised.

## Test plan
- Reset with `tick100` held high, then release. Press start and apply no tick edges for 1000 cycles → digits remain 00:00.00 and `running`=1.
- From IDLE, press start, then apply 123 tick edges → 00:01.23. Press start → PAUSED, `running`=0. Apply 10 more tick edges → still 00:01.23.
- Preload to 59:59.99 by driving 359 999 ticks in RUN (default `MIN_LIMIT`), then apply one more tick → 00:00.00, `rollover` high for exactly 1 cycle, `running`=1.
- Clear, start and tick all rising in the same cycle while in RUN at 00:05.00 → next cycle 00:00.00, state IDLE, no increment.
- With `STOPWATCH_LAP_EN`: in RUN at 00:02.50, press lap, then apply 50 ticks → outputs hold 00:02.50 and `lap_active`=1. Press lap again → outputs show 00:03.00 and `lap_active`=0.
- With `MIN_LIMIT`=2: count from 01:59.99 plus one tick → 00:00.00 with a `rollover` pulse.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: six-digit BCD stopwatch (MM:SS.cc) advanced by the rising
// edges of a 100 Hz square wave sampled in the clk domain.
// Optional lap freeze: define STOPWATCH_LAP_EN to compile in the hold
// registers; without it btn_lap is ignored and lap_active is tied low.
// state_dbg exposes the FSM state register for debug/observation.
module stopwatch_bcd #(
    parameter int MIN_LIMIT = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick100,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens,
    output logic [3:0] m_ones,
    output logic [3:0] m_tens,
    output logic       running,
    output logic       lap_active,
    output logic       rollover,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;

    localparam logic [3:0] MIN_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_ONES = 4'(MIN_LIMIT % 10);

    logic       tick_q, start_q, clear_q;
    logic       tick_ev, start_ev, clear_ev;
    logic [1:0] state, state_n;

    // live count digits and their next values
    logic [3:0] cso_r, cst_r, so_r, st_r, mo_r, mt_r;
    logic [3:0] cso_n, cst_n, so_n, st_n, mo_n, mt_n;
    logic [3:0] mo_inc, mt_inc;
    logic       inc, c_cso, c_cst, c_so, c_st, wrap;

    assign tick_ev  = tick100   & ~tick_q;
    assign start_ev = btn_start & ~start_q;
    assign clear_ev = btn_clear & ~clear_q;
    assign state_dbg = state;

    // next FSM state from a start event (clear is handled at the register)
    always_comb begin
        state_n = state;
        if (start_ev) begin
            case (state)
                IDLE:    state_n = RUN;
                RUN:     state_n = PAUSED;
                PAUSED:  state_n = RUN;
                default: state_n = IDLE;
            endcase
        end
    end

    // BCD ripple increment; every next value is a legal digit
    always_comb begin
        inc   = tick_ev & (state == RUN);
        c_cso = inc   & (cso_r == 4'd9);
        c_cst = c_cso & (cst_r == 4'd9);
        c_so  = c_cst & (so_r  == 4'd9);
        c_st  = c_so  & (st_r  == 4'd5);

        cso_n = inc   ? ((cso_r == 4'd9) ? 4'd0 : cso_r + 4'd1) : cso_r;
        cst_n = c_cso ? ((cst_r == 4'd9) ? 4'd0 : cst_r + 4'd1) : cst_r;
        so_n  = c_cst ? ((so_r  == 4'd9) ? 4'd0 : so_r  + 4'd1) : so_r;
        st_n  = c_so  ? ((st_r  == 4'd5) ? 4'd0 : st_r  + 4'd1) : st_r;

        if (mo_r == 4'd9) begin
            mo_inc = 4'd0;
            mt_inc = mt_r + 4'd1;
        end else begin
            mo_inc = mo_r + 4'd1;
            mt_inc = mt_r;
        end

        wrap = c_st & (mt_inc == MIN_TENS) & (mo_inc == MIN_ONES);
        mo_n = mo_r;
        mt_n = mt_r;
        if (wrap) begin
            mo_n = 4'd0;
            mt_n = 4'd0;
        end else if (c_st) begin
            mo_n = mo_inc;
            mt_n = mt_inc;
        end
    end

    // edge registers, FSM, live count and rollover pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_q   <= 1'b1;
            start_q  <= 1'b0;
            clear_q  <= 1'b0;
            state    <= IDLE;
            running  <= 1'b0;
            rollover <= 1'b0;
            cso_r <= 4'd0; cst_r <= 4'd0; so_r <= 4'd0;
            st_r  <= 4'd0; mo_r  <= 4'd0; mt_r <= 4'd0;
        end else begin
            tick_q  <= tick100;
            start_q <= btn_start;
            clear_q <= btn_clear;
            if (clear_ev) begin
                state    <= IDLE;
                running  <= 1'b0;
                rollover <= 1'b0;
                cso_r <= 4'd0; cst_r <= 4'd0; so_r <= 4'd0;
                st_r  <= 4'd0; mo_r  <= 4'd0; mt_r <= 4'd0;
            end else begin
                state    <= state_n;
                running  <= (state_n == RUN);
                rollover <= wrap;
                cso_r <= cso_n; cst_r <= cst_n; so_r <= so_n;
                st_r  <= st_n;  mo_r  <= mo_n;  mt_r <= mt_n;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_q, lap_ev;
    logic [3:0] h_cso, h_cst, h_so, h_st, h_mo, h_mt;

    assign lap_ev = btn_lap & ~lap_q;

    // lap freeze: capture the live count in RUN, any second lap releases
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lap_q      <= 1'b0;
            lap_active <= 1'b0;
            h_cso <= 4'd0; h_cst <= 4'd0; h_so <= 4'd0;
            h_st  <= 4'd0; h_mo  <= 4'd0; h_mt <= 4'd0;
        end else begin
            lap_q <= btn_lap;
            if (clear_ev) begin
                lap_active <= 1'b0;
            end else if (lap_ev) begin
                if (lap_active) begin
                    lap_active <= 1'b0;
                end else if (state == RUN) begin
                    lap_active <= 1'b1;
                    h_cso <= cso_r; h_cst <= cst_r; h_so <= so_r;
                    h_st  <= st_r;  h_mo  <= mo_r;  h_mt <= mt_r;
                end
            end
        end
    end

    assign cs_ones = lap_active ? h_cso : cso_r;
    assign cs_tens = lap_active ? h_cst : cst_r;
    assign s_ones  = lap_active ? h_so  : so_r;
    assign s_tens  = lap_active ? h_st  : st_r;
    assign m_ones  = lap_active ? h_mo  : mo_r;
    assign m_tens  = lap_active ? h_mt  : mt_r;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_active = 1'b0;
    assign cs_ones = cso_r;
    assign cs_tens = cst_r;
    assign s_ones  = so_r;
    assign s_tens  = st_r;
    assign m_ones  = mo_r;
    assign m_tens  = mt_r;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Testbench for stopwatch_bcd: a default-limit instance and a MIN_LIMIT=2
// instance share the same stimulus and are compared against a model that
// keeps the elapsed time as a plain integer count of hundredths.
module tb_stopwatch_bcd;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick100 = 1'b0;
    logic btn_start = 1'b0;
    logic btn_clear = 1'b0;
    logic btn_lap = 1'b0;

    logic [3:0] a_cso, a_cst, a_so, a_st, a_mo, a_mt;
    logic [3:0] b_cso, b_cst, b_so, b_st, b_mo, b_mt;
    logic       a_run, a_lap, a_roll, b_run, b_lap, b_roll;
    logic [1:0] a_state, b_state;
    logic [23:0] d0, d1;

    int vectors = 0;
    int fails = 0;

    // model state: elapsed hundredths per instance, mode 0 idle/1 run/2 paused
    int m_cnt[2];
    int m_hold[2];
    bit m_roll[2];
    int m_wrap[2];
    int m_mode;
    bit m_lap;
    bit p_tick, p_start, p_clear, p_lap;

    // clock / reset
    always #10 clk = ~clk;

    stopwatch_bcd dut0 (
        .clk(clk), .reset_n(reset_n), .tick100(tick100),
        .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .cs_ones(a_cso), .cs_tens(a_cst), .s_ones(a_so), .s_tens(a_st),
        .m_ones(a_mo), .m_tens(a_mt), .running(a_run), .lap_active(a_lap),
        .rollover(a_roll), .state_dbg(a_state)
    );

    stopwatch_bcd #(.MIN_LIMIT(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .tick100(tick100),
        .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .cs_ones(b_cso), .cs_tens(b_cst), .s_ones(b_so), .s_tens(b_st),
        .m_ones(b_mo), .m_tens(b_mt), .running(b_run), .lap_active(b_lap),
        .rollover(b_roll), .state_dbg(b_state)
    );

    assign d0 = {a_mt, a_mo, a_st, a_so, a_cst, a_cso};
    assign d1 = {b_mt, b_mo, b_st, b_so, b_cst, b_cso};

    function automatic logic [23:0] to_bcd(input int n);
        int cs, s, m;
        cs = n % 100;
        s  = (n / 100) % 60;
        m  = n / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic logic [23:0] exp_disp(input int i);
        return to_bcd(m_lap ? m_hold[i] : m_cnt[i]);
    endfunction

    // driver: apply one cycle of inputs, advance the model at the edge
    task automatic step(input bit t, input bit s, input bit c, input bit l);
        bit te, se, ce, le;
        tick100 = t; btn_start = s; btn_clear = c; btn_lap = l;
        @(posedge clk);
        te = t & ~p_tick; se = s & ~p_start; ce = c & ~p_clear; le = l & ~p_lap;
        p_tick = t; p_start = s; p_clear = c; p_lap = l;
        if (ce) begin
            for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_roll[i] = 0; end
            m_mode = 0;
            m_lap = 0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (le) begin
                if (m_lap) m_lap = 0;
                else if (m_mode == 1) begin
                    m_lap = 1;
                    for (int i = 0; i < 2; i++) m_hold[i] = m_cnt[i];
                end
            end
`endif
            for (int i = 0; i < 2; i++) begin
                m_roll[i] = 0;
                if (te && m_mode == 1) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == m_wrap[i]) begin
                        m_cnt[i] = 0;
                        m_roll[i] = 1;
                    end
                end
            end
            if (se) m_mode = (m_mode == 1) ? 2 : 1;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    endtask

    task automatic press_start();
        step(0, 1, 0, 0); step(0, 0, 0, 0);
    endtask

    task automatic press_clear();
        step(0, 0, 1, 0); step(0, 0, 0, 0);
    endtask

    task automatic press_lap();
        step(0, 0, 0, 1); step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick100 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_mode = 0; m_lap = 0;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_hold[i] = 0; m_roll[i] = 0; end
        p_tick = 1; p_start = 0; p_clear = 0; p_lap = 0;
        vectors++;
        if (d0 !== 24'h0 || a_run !== 1'b0 || a_lap !== 1'b0 || a_roll !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got d=%h run=%b lap=%b roll=%b want 000000/0/0/0", d0, a_run, a_lap, a_roll);
        end
        reset_n = 1'b1;
        repeat (5) step(1, 0, 0, 0);
        vectors++;
        if (d0 !== 24'h0 || a_run !== 1'b0) begin
            fails++;
            $display("FAIL reset_tick_high got d=%h run=%b want 000000/0", d0, a_run);
        end
        step(1, 1, 0, 0);
        repeat (999) step(1, 0, 0, 0);
        vectors++;
        if (d0 !== 24'h0 || a_run !== 1'b1) begin
            fails++;
            $display("FAIL no_tick_edges got d=%h run=%b want 000000/1", d0, a_run);
        end
        step(0, 0, 0, 0);
        press_clear();
    endtask

    task automatic test_count();
        press_start();
        ticks(123);
        vectors++;
        if (d0 !== 24'h000123 || d1 !== 24'h000123) begin
            fails++;
            $display("FAIL count_123 got %h/%h want 000123", d0, d1);
        end
        press_start();
        vectors++;
        if (a_run !== 1'b0) begin
            fails++;
            $display("FAIL pause_running got %b want 0", a_run);
        end
        ticks(10);
        vectors++;
        if (d0 !== 24'h000123) begin
            fails++;
            $display("FAIL paused_hold got %h want 000123", d0);
        end
        press_clear();
    endtask

    task automatic test_rollover();
        press_start();
        ticks(11999);
        vectors++;
        if (d1 !== 24'h015999) begin
            fails++;
            $display("FAIL preload_limit2 got %h want 015999", d1);
        end
        step(1, 0, 0, 0);
        vectors++;
        if (d1 !== 24'h0 || b_roll !== 1'b1 || b_run !== 1'b1) begin
            fails++;
            $display("FAIL wrap_limit2 got d=%h roll=%b run=%b want 000000/1/1", d1, b_roll, b_run);
        end
        vectors++;
        if (d0 !== 24'h020000 || a_roll !== 1'b0) begin
            fails++;
            $display("FAIL no_wrap_default got d=%h roll=%b want 020000/0", d0, a_roll);
        end
        step(0, 0, 0, 0);
        vectors++;
        if (b_roll !== 1'b0) begin
            fails++;
            $display("FAIL roll_pulse_width got %b want 0", b_roll);
        end
        press_clear();
    endtask

    task automatic test_priority();
        press_start();
        ticks(500);
        vectors++;
        if (d0 !== 24'h000500) begin
            fails++;
            $display("FAIL count_500 got %h want 000500", d0);
        end
        step(1, 1, 1, 0);
        vectors++;
        if (d0 !== 24'h0 || a_run !== 1'b0) begin
            fails++;
            $display("FAIL clear_wins got d=%h run=%b want 000000/0", d0, a_run);
        end
        step(0, 0, 0, 0);
        ticks(1);
        vectors++;
        if (d0 !== 24'h0) begin
            fails++;
            $display("FAIL idle_no_count got %h want 000000", d0);
        end
        step(1, 1, 0, 0);
        vectors++;
        if (d0 !== 24'h0 || a_run !== 1'b1) begin
            fails++;
            $display("FAIL idle_start_tick got d=%h run=%b want 000000/1", d0, a_run);
        end
        step(0, 0, 0, 0);
        ticks(1);
        vectors++;
        if (d0 !== 24'h000001) begin
            fails++;
            $display("FAIL first_tick got %h want 000001", d0);
        end
        press_clear();
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0, 0);
        repeat (5) begin step(1, 1, 0, 0); step(0, 1, 0, 0); end
        vectors++;
        if (a_run !== 1'b1 || d0 !== 24'h000005) begin
            fails++;
            $display("FAIL held_start got run=%b d=%h want 1/000005", a_run, d0);
        end
        step(0, 0, 0, 0);
        press_clear();
    endtask

    task automatic test_lap();
        press_start();
        ticks(250);
        press_lap();
        ticks(50);
`ifdef STOPWATCH_LAP_EN
        vectors++;
        if (d0 !== 24'h000250 || a_lap !== 1'b1) begin
            fails++;
            $display("FAIL lap_hold got d=%h lap=%b want 000250/1", d0, a_lap);
        end
        press_lap();
        vectors++;
        if (d0 !== 24'h000300 || a_lap !== 1'b0) begin
            fails++;
            $display("FAIL lap_release got d=%h lap=%b want 000300/0", d0, a_lap);
        end
`else
        vectors++;
        if (d0 !== 24'h000300 || a_lap !== 1'b0) begin
            fails++;
            $display("FAIL lap_ignored got d=%h lap=%b want 000300/0", d0, a_lap);
        end
`endif
        press_clear();
    endtask

    task automatic test_random();
        bit t, s, c, l;
        for (int n = 0; n < 4000; n++) begin
            t = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 149) == 0);
            l = ($urandom_range(0, 29) == 0);
            step(t, s, c, l);
            vectors++;
            if (d0 !== exp_disp(0) || d1 !== exp_disp(1)) begin
                fails++;
                $display("FAIL rand_digits cyc %0d got %h/%h want %h/%h", n, d0, d1, exp_disp(0), exp_disp(1));
            end
            vectors++;
            if (a_run !== (m_mode == 1) || b_run !== (m_mode == 1)) begin
                fails++;
                $display("FAIL rand_running cyc %0d got %b/%b want %b", n, a_run, b_run, m_mode == 1);
            end
            vectors++;
            if (a_lap !== m_lap || a_roll !== m_roll[0] || b_roll !== m_roll[1]) begin
                fails++;
                $display("FAIL rand_flags cyc %0d got lap=%b roll=%b/%b want %b %b/%b", n, a_lap, a_roll, b_roll, m_lap, m_roll[0], m_roll[1]);
            end
        end
    endtask

    initial begin
        m_wrap[0] = 60 * 6000;
        m_wrap[1] = 2 * 6000;
        test_reset();
        test_count();
        test_rollover();
        test_priority();
        test_back_to_back();
        test_lap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
